// File: rtl/ets_sweep_sequencer.sv
// ETS phase-sweep sequencer: per phase step, measures each enabled channel,
// streams packed results, then requests one clock-source phase shift.
module ets_sweep_sequencer #(
   parameter int TO_W     = 12,
   parameter int SETTLE_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [13:0]         num_steps,
   input  logic [3:0]          ch_mask,
   input  logic [SETTLE_W-1:0] settle_cycles,
   output logic [1:0]          sw,
   output logic                shift,
   input  logic                shift_done,
   output logic                acc_start,
   input  logic                acc_done,
   input  logic [31:0]         acc_data,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic [31:0]         m_axis_tdata,
   output logic                m_axis_tlast,
   output logic                busy,
   output logic                done_pulse,
   output logic                err
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_SETTLE, S_ACQ, S_ACQ_CLR, S_EMIT, S_SHIFT, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [13:0]         step_q, step_d;
   logic [13:0]         nsteps_q, nsteps_d;
   logic [3:0]          mask_q, mask_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic [1:0]          ch_q, ch_d;
   logic [1:0]          sw_q, sw_d;
   logic [15:0]         count_q, count_d;
   logic                err_q, err_d;
   logic                abort_q, abort_d;

   logic                xfer;
   logic                abort_any;
   logic                last_step;
   logic                more_ch;
   logic [1:0]          next_ch;

   function automatic logic [1:0] lowest_ch(input logic [3:0] m);
      lowest_ch = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (m[i]) lowest_ch = 2'(i);
   endfunction

   always_comb begin
      more_ch = 1'b0;
      next_ch = ch_q;
      for (int i = 3; i >= 0; i--) begin
         if (mask_q[i] && (2'(i) > ch_q)) begin
            more_ch = 1'b1;
            next_ch = 2'(i);
         end
      end
   end

   assign xfer      = (state_q == S_EMIT) && m_axis_tready;
   assign abort_any = abort | abort_q;
   assign last_step = (step_q == nsteps_q - 14'd1);

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      nsteps_d = nsteps_q;
      mask_d   = mask_q;
      settle_d = settle_q;
      cnt_d    = cnt_q;
      to_d     = '0;
      ch_d     = ch_q;
      sw_d     = sw_q;
      count_d  = count_q;
      err_d    = err_q;
      // abort is latched so a one-cycle request survives to the next safe point
      abort_d  = (state_q == S_IDLE) ? 1'b0 : (abort_q | abort);
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               nsteps_d = num_steps;
               mask_d   = ch_mask;
               settle_d = settle_cycles;
               step_d   = 14'd0;
               err_d    = 1'b0;
               ch_d     = lowest_ch(ch_mask);
               if (num_steps == 14'd0 || ch_mask == 4'd0)
                  state_d = S_DONE;
               else
                  state_d = S_SEL;
            end
         end
         S_SEL: begin
            if (abort_any) begin
               state_d = S_DONE;
            end else begin
               sw_d    = ch_q;
               cnt_d   = settle_q;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (abort_any)
               state_d = S_DONE;
            else if (cnt_q == '0)
               state_d = S_ACQ;
            else
               cnt_d = cnt_q - 1'b1;
         end
         S_ACQ: begin
            if (abort_any) begin
               state_d = S_ACQ_CLR;
            end else if (acc_done) begin
               count_d = (|acc_data[31:16]) ? 16'hFFFF : acc_data[15:0];
               state_d = S_ACQ_CLR;
            end
         end
         S_ACQ_CLR: begin
            if (abort_any)
               state_d = S_DONE;
            else if (!acc_done)
               state_d = S_EMIT;
         end
         S_EMIT: begin
            if (xfer) begin
               if (more_ch) begin
                  ch_d    = next_ch;
                  state_d = S_SEL;
               end else if (last_step) begin
                  state_d = S_DONE;
               end else begin
                  ch_d    = lowest_ch(mask_q);
                  state_d = S_SHIFT;
               end
            end else if (abort_any) begin
               state_d = S_DONE;
            end
         end
         S_SHIFT: begin
            if (shift_done) begin
               if (abort_any) begin
                  state_d = S_DONE;
               end else begin
                  step_d  = step_q + 14'd1;
                  state_d = S_SEL;
               end
            end else if (to_q == {TO_W{1'b1}}) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         step_q   <= '0;
         nsteps_q <= '0;
         mask_q   <= '0;
         settle_q <= '0;
         cnt_q    <= '0;
         to_q     <= '0;
         ch_q     <= '0;
         sw_q     <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         nsteps_q <= nsteps_d;
         mask_q   <= mask_d;
         settle_q <= settle_d;
         cnt_q    <= cnt_d;
         to_q     <= to_d;
         ch_q     <= ch_d;
         sw_q     <= sw_d;
         count_q  <= count_d;
         err_q    <= err_d;
         abort_q  <= abort_d;
      end
   end

   assign sw            = sw_q;
   assign shift         = (state_q == S_SHIFT);
   assign acc_start     = (state_q == S_ACQ);
   assign m_axis_tvalid = (state_q == S_EMIT);
   assign m_axis_tlast  = (state_q == S_EMIT) && last_step && !more_ch;
   assign m_axis_tdata  = {ch_q, step_q, count_q};
   assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_pulse    = (state_q == S_DONE);
   assign err           = err_q;

endmodule

// File: tb/tb_ets_sweep_sequencer.sv
// Randomized bench for ets_sweep_sequencer: bench-side responders for the
// averaging counter, clock source and stream sink; results scored vs a model.
module tb_ets_sweep_sequencer;

   localparam int TO_W     = 4;
   localparam int SETTLE_W = 8;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic                abort = 1'b0;
   logic [13:0]         num_steps = '0;
   logic [3:0]          ch_mask = '0;
   logic [SETTLE_W-1:0] settle_cycles = '0;
   logic [1:0]          sw;
   logic                shift;
   logic                shift_done = 1'b0;
   logic                acc_start;
   logic                acc_done = 1'b0;
   logic [31:0]         acc_data = '0;
   logic                m_axis_tvalid;
   logic                m_axis_tready = 1'b1;
   logic [31:0]         m_axis_tdata;
   logic                m_axis_tlast;
   logic                busy;
   logic                done_pulse;
   logic                err;

   ets_sweep_sequencer #(.TO_W(TO_W), .SETTLE_W(SETTLE_W)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .num_steps(num_steps), .ch_mask(ch_mask),
      .settle_cycles(settle_cycles), .sw(sw), .shift(shift),
      .shift_done(shift_done), .acc_start(acc_start),
      .acc_done(acc_done), .acc_data(acc_data),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .busy(busy), .done_pulse(done_pulse), .err(err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // environment state
   bit          acc_en = 1'b1;
   bit          use_fixed = 1'b0;
   logic [31:0] fixed_data = '0;
   int          acc_wait = 0;
   int          sd_delay = 5;
   int          sd_wait = 0;
   bit          rdy_rand = 1'b0;
   int          stall_left = 0;
   bit          stab_en = 1'b1;
   bit          chk_en = 1'b1;
   int          shifts = 0;
   int          words_at_shift1 = -1;
   logic [31:0] data_q[$];
   logic [1:0]  sw_log[$];
   logic [31:0] word_q[$];
   logic        last_q[$];

   logic        p_acc_done = 0, p_acc_start = 0;
   logic        p_shift_done = 0, p_shift = 0;
   logic        p_tvalid = 0, p_tready = 0, p_tlast = 0;
   logic [31:0] p_tdata = '0;

   function automatic logic [31:0] rnd_data();
      case ($urandom_range(0, 5))
         0:       rnd_data = 32'h0000FFFF;
         1:       rnd_data = 32'h00010000;
         2:       rnd_data = $urandom | 32'h00010000;
         default: rnd_data = 32'($urandom_range(0, 65535));
      endcase
   endfunction

   function automatic logic [1:0] lowbit(input logic [3:0] m);
      lowbit = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (m[i]) lowbit = 2'(i);
   endfunction

   always @(negedge clk) begin
      if (chk_en && p_acc_done && p_acc_start)
         chk("acc_drop", acc_start, 0);
      if (chk_en && p_shift_done && p_shift)
         chk("shift_drop", shift, 0);
      if (stab_en && p_tvalid && !p_tready) begin
         chk("hold_valid", m_axis_tvalid, 1);
         chk("hold_data", m_axis_tdata, p_tdata);
      end
      if (chk_en && p_tvalid && p_tready) begin
         word_q.push_back(p_tdata);
         last_q.push_back(p_tlast);
      end
      if (shift && !p_shift) begin
         shifts++;
         if (shifts == 1) words_at_shift1 = word_q.size();
      end

      if (!acc_start) begin
         acc_wait = $urandom_range(0, 3);
         if (acc_done && $urandom_range(0, 2) != 0) acc_done = 1'b0;
      end else if (!acc_done && acc_en) begin
         if (acc_wait == 0) begin
            acc_done = 1'b1;
            acc_data = use_fixed ? fixed_data : rnd_data();
            data_q.push_back(acc_data);
            sw_log.push_back(sw);
         end else begin
            acc_wait--;
         end
      end

      if (shift_done) begin
         shift_done = 1'b0;
      end else if (shift && sd_delay >= 0) begin
         if (!p_shift) sd_wait = sd_delay;
         if (sd_wait == 0) shift_done = 1'b1;
         else sd_wait--;
      end

      if (stall_left > 0) begin
         m_axis_tready = 1'b0;
         if (m_axis_tvalid) stall_left--;
      end else begin
         m_axis_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end

      p_acc_done   = acc_done;
      p_acc_start  = acc_start;
      p_shift_done = shift_done;
      p_shift      = shift;
      p_tvalid     = m_axis_tvalid;
      p_tready     = m_axis_tready;
      p_tdata      = m_axis_tdata;
      p_tlast      = m_axis_tlast;
   end

   task automatic clr();
      word_q.delete();
      last_q.delete();
      data_q.delete();
      sw_log.delete();
      shifts = 0;
      words_at_shift1 = -1;
   endtask

   task automatic kick(input int n, input logic [3:0] m, input int st);
      num_steps     = 14'(n);
      ch_mask       = m;
      settle_cycles = SETTLE_W'(st);
      start         = 1'b1;
      @(negedge clk);
      start         = 1'b0;
   endtask

   task automatic run(input int n, input logic [3:0] m, input int st);
      int  k;
      bit  live;
      live = (n != 0) && (m != 0);
      clr();
      kick(n, m, st);
      chk("busy_t1", busy, 32'(live));
      chk("err_clr", err, 0);
      if (!live) begin
         chk("deg_done", done_pulse, 1);
      end else begin
         @(negedge clk);
         chk("sw_t2", sw, lowbit(m));
         for (int j = 0; j < st; j++) @(negedge clk);
         chk("acc_pre", acc_start, 0);
         @(negedge clk);
         chk("acc_t3", acc_start, 1);
         k = 0;
         while (!done_pulse && k < 4000) begin
            @(negedge clk);
            k++;
         end
         chk("done", done_pulse, 1);
      end
      chk("busy_end", busy, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic score(input int n, input logic [3:0] m);
      logic [1:0]  ec[$];
      int          es[$];
      logic [31:0] d;
      logic [31:0] w;
      for (int s = 0; s < n; s++)
         for (int c = 0; c < 4; c++)
            if (m[c]) begin
               ec.push_back(2'(c));
               es.push_back(s);
            end
      chk("nwords", word_q.size(), ec.size());
      chk("nacq", data_q.size(), ec.size());
      for (int i = 0; i < ec.size(); i++) begin
         d = (i < data_q.size()) ? data_q[i] : 32'h0;
         w = {ec[i], 14'(es[i]), (d > 32'hFFFF) ? 16'hFFFF : d[15:0]};
         if (i < word_q.size()) begin
            chk($sformatf("word%0d", i), word_q[i], w);
            chk($sformatf("tlast%0d", i), last_q[i], 32'(i == ec.size() - 1));
         end
         if (i < sw_log.size())
            chk($sformatf("sw%0d", i), sw_log[i], ec[i]);
      end
      if (ec.size() > 0) chk("shifts", shifts, n - 1);
   endtask

   initial begin
      int          k;
      int          rn;
      int          rs;
      logic [3:0]  rm;
      logic [31:0] sc_exp[3];

      repeat (3) @(negedge clk);
      chk("rst_sw", sw, 0);
      chk("rst_shift", shift, 0);
      chk("rst_acc", acc_start, 0);
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done_pulse, 0);
      chk("rst_err", err, 0);
      reset = 1'b0;
      @(negedge clk);

      // single channel
      use_fixed  = 1'b1;
      fixed_data = 32'd1024;
      sd_delay   = 5;
      run(3, 4'b0001, 4);
      score(3, 4'b0001);
      sc_exp[0] = 32'h00000400;
      sc_exp[1] = 32'h00010400;
      sc_exp[2] = 32'h00020400;
      for (int i = 0; i < 3; i++)
         if (i < word_q.size())
            chk($sformatf("sc_word%0d", i), word_q[i], sc_exp[i]);
      chk("sc_shifts", shifts, 2);

      // multi-channel ordering
      use_fixed = 1'b0;
      run(2, 4'b1010, 1);
      score(2, 4'b1010);
      chk("mc_shift_pos", words_at_shift1, 2);

      // saturation under backpressure
      use_fixed  = 1'b1;
      fixed_data = 32'h00012345;
      stall_left = 10;
      run(1, 4'b0001, 2);
      score(1, 4'b0001);
      if (word_q.size() > 0) chk("sat_word", word_q[0], 32'h0000FFFF);
      use_fixed = 1'b0;

      // shift timeout
      sd_delay = -1;
      clr();
      kick(2, 4'b0001, 0);
      k = 0;
      while (!shift && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("to_shift", shift, 1);
      k = 0;
      while (!err && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("to_len", k, 16);
      chk("to_shift_drop", shift, 0);
      chk("to_done", done_pulse, 1);
      @(negedge clk);
      chk("to_busy", busy, 0);
      chk("to_sticky", err, 1);
      sd_delay = 5;
      repeat (2) @(negedge clk);

      // degenerate configurations
      run(0, 4'b0101, 3);
      score(0, 4'b0101);
      run(3, 4'b0000, 1);
      score(3, 4'b0000);

      // abort while shifting
      sd_delay = 6;
      clr();
      kick(3, 4'b0001, 1);
      k = 0;
      while (!shift && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("ab_shift", shift, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      k = 0;
      while (shift && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("ab_shift_end", shift, 0);
      chk("ab_done", done_pulse, 1);
      repeat (2) @(negedge clk);
      chk("ab_words", word_q.size(), 1);
      if (last_q.size() > 0) chk("ab_tlast", last_q[0], 0);
      chk("ab_shifts", shifts, 1);

      // reset in the middle of an acquisition
      acc_en  = 1'b0;
      chk_en  = 1'b0;
      stab_en = 1'b0;
      clr();
      kick(2, 4'b0001, 0);
      k = 0;
      while (!acc_start && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("rm_acq", acc_start, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("rm_acc", acc_start, 0);
      chk("rm_busy", busy, 0);
      chk("rm_done", done_pulse, 0);
      chk("rm_tvalid", m_axis_tvalid, 0);
      chk("rm_sw", sw, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("rm_no_done", done_pulse, 0);
      acc_en  = 1'b1;
      chk_en  = 1'b1;
      stab_en = 1'b1;
      run(2, 4'b0110, 2);
      score(2, 4'b0110);

      // randomized sweeps
      rdy_rand = 1'b1;
      for (int r = 0; r < 6; r++) begin
         rn       = $urandom_range(1, 4);
         rm       = 4'($urandom_range(1, 15));
         rs       = $urandom_range(0, 5);
         sd_delay = $urandom_range(0, 8);
         if (r % 2 == 1) stall_left = $urandom_range(0, 6);
         run(rn, rm, rs);
         score(rn, rm);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
